// File: rtl/dp_trace_pkg.sv
// Shared definitions for the datapath trace buffer.
// DP_TRACE_TIMESTAMP_EN adds a TS_W-bit cycle stamp to every stored entry.
package dp_trace_pkg;

    localparam int unsigned TS_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        POST  = 2'd2,
        DRAIN = 2'd3
    } trace_state_t;

    // Packed entry is {pc, rd1, rd2[, ts]}; the struct itself lives beside XLEN in the top.
    function automatic int unsigned entry_width(input int unsigned xlen);
        int unsigned w;
        w = 3 * xlen;
`ifdef DP_TRACE_TIMESTAMP_EN
        w = w + TS_W;
`endif
        return w;
    endfunction

endpackage

// File: rtl/dp_trace_ram.sv
// Trace storage: DEPTH x WIDTH, synchronous write, registered read.
// The read register clears asynchronously so the drain port reads zero out of reset.
module dp_trace_ram #(
    parameter int unsigned WIDTH = 192,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/dp_trace_buffer.sv
// Circular {PC, rd1, rd2} trace with PC trigger, post-trigger capture and valid/ready drain.
// Define DP_TRACE_TIMESTAMP_EN to store a free-running cycle stamp per entry and add rd_ts.
module dp_trace_buffer
    import dp_trace_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POST_TRIG = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   arm,
    input  logic                   abort,
    input  logic [XLEN-1:0]        trig_pc,
    input  logic                   cap_valid,
    input  logic [XLEN-1:0]        cap_pc,
    input  logic [XLEN-1:0]        cap_rd1,
    input  logic [XLEN-1:0]        cap_rd2,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [XLEN-1:0]        rd_pc,
    output logic [XLEN-1:0]        rd_rd1,
    output logic [XLEN-1:0]        rd_rd2,
`ifdef DP_TRACE_TIMESTAMP_EN
    output logic [TS_W-1:0]        rd_ts,
`endif
    output logic                   busy,
    output logic                   triggered,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = entry_width(XLEN);

    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
`ifdef DP_TRACE_TIMESTAMP_EN
        logic [TS_W-1:0] ts;
`endif
    } entry_t;

    trace_state_t  state;
    trace_state_t  state_next;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] post_cnt;
    logic [AW-1:0] oldest;
    logic [AW-1:0] rd_addr;
    logic          capture;
    logic          trig_hit;
    logic          pop;
    logic          last_pop;
    logic          load_rd;
    logic          ram_we;
    logic          ram_re;
    entry_t        wr_entry;
    entry_t        rd_entry;

`ifdef DP_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
        end
    end
`endif

    always_comb begin
        capture  = cap_valid && ((state == PRE) || (state == POST));
        trig_hit = cap_valid && (state == PRE) && (cap_pc == trig_pc);
        pop      = (state == DRAIN) && rd_valid && rd_ready;
        last_pop = pop && (count == CNT_ONE);
        load_rd  = (state == DRAIN) && (!rd_valid || rd_ready);
        oldest   = wr_ptr - count[AW-1:0];
        // On a pop the read register must already fetch the entry after the one leaving.
        rd_addr  = pop ? (oldest + PTR_ONE) : oldest;
        ram_we   = capture && !abort;
        ram_re   = load_rd && !abort;
    end

    always_comb begin
        wr_entry     = '0;
        wr_entry.pc  = cap_pc;
        wr_entry.rd1 = cap_rd1;
        wr_entry.rd2 = cap_rd2;
`ifdef DP_TRACE_TIMESTAMP_EN
        wr_entry.ts  = ts_cnt;
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_next = PRE;
                end
            end
            PRE: begin
                if (trig_hit) begin
                    state_next = (POST_TRIG == 0) ? DRAIN : POST;
                end
            end
            POST: begin
                if (cap_valid && (post_cnt == PTR_ONE)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if ((count == '0) || last_pop) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            count     <= '0;
            post_cnt  <= '0;
            triggered <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            state <= state_next;
            if (abort) begin
                wr_ptr    <= '0;
                count     <= '0;
                post_cnt  <= '0;
                triggered <= 1'b0;
                rd_valid  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            wr_ptr <= '0;
                            count  <= '0;
                        end
                    end
                    PRE, POST: begin
                        if (capture) begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                            if (count != CNT_FULL) begin
                                count <= count + CNT_ONE;
                            end
                            if (trig_hit) begin
                                triggered <= 1'b1;
                                post_cnt  <= POST_INIT;
                            end else if (state == POST) begin
                                post_cnt <= post_cnt - PTR_ONE;
                            end
                        end
                    end
                    DRAIN: begin
                        if (pop) begin
                            count <= count - CNT_ONE;
                        end
                        if (load_rd) begin
                            rd_valid <= pop ? (count != CNT_ONE) : (count != '0);
                        end
                        if (state_next == IDLE) begin
                            triggered <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    dp_trace_ram #(
        .WIDTH(EW),
        .DEPTH(DEPTH)
    ) u_ram (
        .clock(clock),
        .reset(reset),
        .we   (ram_we),
        .waddr(wr_ptr),
        .wdata(wr_entry),
        .re   (ram_re),
        .raddr(rd_addr),
        .rdata(rd_entry)
    );

    assign busy   = (state != IDLE);
    assign rd_pc  = rd_entry.pc;
    assign rd_rd1 = rd_entry.rd1;
    assign rd_rd2 = rd_entry.rd2;
`ifdef DP_TRACE_TIMESTAMP_EN
    assign rd_ts  = rd_entry.ts;
`endif

endmodule

// File: tb/tb_dp_trace_buffer.sv
// Bench for dp_trace_buffer: random captures and drains checked against a queue model of the trace.
module tb_dp_trace_buffer;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned POST_TRIG = 8;
    localparam int unsigned CW        = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] rd1;
        logic [63:0] rd2;
        logic [31:0] ts;
    } ent_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          arm, abort, cap_valid, rd_ready;
    logic [63:0]   trig_pc, cap_pc, cap_rd1, cap_rd2;
    logic          rd_valid, busy, triggered;
    logic [63:0]   rd_pc, rd_rd1, rd_rd2;
    logic [CW-1:0] count;
`ifdef DP_TRACE_TIMESTAMP_EN
    logic [31:0]   rd_ts;
`endif

    ent_t        model_q[$];
    logic [31:0] cyc;
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_fail   = 0;

    dp_trace_buffer #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .POST_TRIG(POST_TRIG)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .arm      (arm),
        .abort    (abort),
        .trig_pc  (trig_pc),
        .cap_valid(cap_valid),
        .cap_pc   (cap_pc),
        .cap_rd1  (cap_rd1),
        .cap_rd2  (cap_rd2),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_pc    (rd_pc),
        .rd_rd1   (rd_rd1),
        .rd_rd2   (rd_rd2),
`ifdef DP_TRACE_TIMESTAMP_EN
        .rd_ts    (rd_ts),
`endif
        .busy     (busy),
        .triggered(triggered),
        .count    (count)
    );

    always #5 clock = ~clock;

    // Cycle number seen by a capture, i.e. the stamp the entry should carry.
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 32'd0;
        else       cyc <= cyc + 32'd1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rand_pc(input logic [63:0] avoid);
        logic [63:0] v;
        do begin
            v = {$urandom, $urandom} & ~64'h3;
        end while (v == avoid);
        return v;
    endfunction

    // seq=1: PCs 0,4,8,... ; seq=0: random PCs with the trigger at capture number trig_idx.
    task automatic capture_run(input logic [63:0] tpc, input bit seq,
                               input int unsigned trig_idx, input int unsigned gap_pct);
        bit          trig  = 1'b0;
        bit          done  = 1'b0;
        int unsigned rem   = 0;
        int unsigned n_cap = 0;
        logic [63:0] pc;
        model_q.delete();
        trig_pc = tpc;
        arm     = 1'b1;
        @(negedge clock);
        arm = 1'b0;
        check("arm_busy", 64'(busy), 64'(1));
        check("arm_count", 64'(count), 64'(0));
        check("arm_triggered", 64'(triggered), 64'(0));
        for (int c = 0; c < 400 && !done; c++) begin
            cap_valid = ($urandom_range(99) >= gap_pct);
            if (seq)                               pc = 64'(n_cap * 4);
            else if (!trig && n_cap == trig_idx)   pc = tpc;
            else if (trig && $urandom_range(3) == 0) pc = tpc;
            else                                   pc = rand_pc(tpc);
            cap_pc  = pc;
            cap_rd1 = {$urandom, $urandom};
            cap_rd2 = {$urandom, $urandom};
            arm     = ($urandom_range(7) == 0);
            if (cap_valid) begin
                model_q.push_back('{pc: pc, rd1: cap_rd1, rd2: cap_rd2, ts: cyc});
                if (model_q.size() > DEPTH) void'(model_q.pop_front());
                n_cap++;
                if (!trig) begin
                    if (pc == tpc) begin
                        trig = 1'b1;
                        rem  = POST_TRIG;
                        done = (rem == 0);
                    end
                end else begin
                    rem--;
                    done = (rem == 0);
                end
            end
            @(negedge clock);
            cap_valid = 1'b0;
            arm       = 1'b0;
            check("cap_count", 64'(count), 64'(model_q.size()));
            check("cap_triggered", 64'(triggered), 64'(trig));
            check("cap_busy", 64'(busy), 64'(1));
        end
        check("capture_done", 64'(done), 64'(1));
    endtask

    // mode 0: rd_ready held high, 1: alternating, 2: random.
    task automatic drain_run(input int unsigned mode);
        check("drain_first_invalid", 64'(rd_valid), 64'(0));
        check("drain_count", 64'(count), 64'(model_q.size()));
        @(negedge clock);
        for (int c = 0; c < 400 && model_q.size() > 0; c++) begin
            check("rd_valid", 64'(rd_valid), 64'(1));
            check("rd_count", 64'(count), 64'(model_q.size()));
            check("rd_pc", rd_pc, model_q[0].pc);
            check("rd_rd1", rd_rd1, model_q[0].rd1);
            check("rd_rd2", rd_rd2, model_q[0].rd2);
`ifdef DP_TRACE_TIMESTAMP_EN
            check("rd_ts", 64'(rd_ts), 64'(model_q[0].ts));
`endif
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = (c % 2 == 1);
                default: rd_ready = ($urandom_range(1) == 1);
            endcase
            cap_valid = ($urandom_range(1) == 1);
            cap_pc    = trig_pc;
            if (rd_ready) void'(model_q.pop_front());
            @(negedge clock);
            rd_ready  = 1'b0;
            cap_valid = 1'b0;
        end
        check("drain_empty", 64'(model_q.size()), 64'(0));
        check("end_rd_valid", 64'(rd_valid), 64'(0));
        check("end_busy", 64'(busy), 64'(0));
        check("end_count", 64'(count), 64'(0));
        check("end_triggered", 64'(triggered), 64'(0));
    endtask

    initial begin
        arm = 1'b0; abort = 1'b0; cap_valid = 1'b0; rd_ready = 1'b0;
        trig_pc = '0; cap_pc = '0; cap_rd1 = '0; cap_rd2 = '0;
        #1 reset = 1'b1;
        #1;
        check("rst_rd_valid", 64'(rd_valid), 64'(0));
        check("rst_rd_pc", rd_pc, 64'(0));
        check("rst_rd_rd1", rd_rd1, 64'(0));
        check("rst_rd_rd2", rd_rd2, 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_triggered", 64'(triggered), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Captures while idle are not recorded
        cap_valid = 1'b1;
        repeat (3) @(negedge clock);
        cap_valid = 1'b0;
        check("idle_count", 64'(count), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));

        // abort beats arm in IDLE
        arm = 1'b1; abort = 1'b1;
        @(negedge clock);
        arm = 1'b0; abort = 1'b0;
        check("abort_arm_busy", 64'(busy), 64'(0));

        // Wrap: PCs 0..72, trigger at 40, oldest surviving entry is PC 12
        capture_run(64'd40, 1'b1, 0, 0);
        check("wrap_count", 64'(count), 64'(16));
        check("wrap_triggered", 64'(triggered), 64'(1));
        drain_run(0);

        // Early trigger on the very first capture, drained with alternating ready
        capture_run(64'd0, 1'b1, 0, 0);
        check("early_count", 64'(count), 64'(POST_TRIG + 1));
        drain_run(1);

        // Random traces with gaps, re-matches of trig_pc after the trigger and random ready
        for (int r = 0; r < 6; r++) begin
            capture_run(rand_pc(64'd0), 1'b0, $urandom_range(25), 30);
            drain_run(2);
        end

        // Abort during POST after two post-trigger captures
        trig_pc = 64'h100;
        arm     = 1'b1;
        @(negedge clock);
        arm = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cap_valid = 1'b1;
            cap_pc    = 64'h100 + 64'(i * 4);
            @(negedge clock);
        end
        cap_valid = 1'b0;
        check("post_triggered", 64'(triggered), 64'(1));
        check("post_count", 64'(count), 64'(3));
        abort = 1'b1; cap_valid = 1'b1;
        @(negedge clock);
        abort = 1'b0; cap_valid = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_count", 64'(count), 64'(0));
        check("abort_triggered", 64'(triggered), 64'(0));
        check("abort_rd_valid", 64'(rd_valid), 64'(0));
        capture_run(rand_pc(64'd0), 1'b0, 5, 20);
        drain_run(2);

        // Abort part-way through a drain
        capture_run(64'd40, 1'b1, 0, 0);
        @(negedge clock);
        rd_ready = 1'b1;
        repeat (2) @(negedge clock);
        rd_ready = 1'b0;
        check("drain_mid_count", 64'(count), 64'(14));
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_drain_busy", 64'(busy), 64'(0));
        check("abort_drain_rd_valid", 64'(rd_valid), 64'(0));
        check("abort_drain_count", 64'(count), 64'(0));

        // Reset between edges while draining clears everything at once
        capture_run(64'd40, 1'b1, 0, 0);
        @(negedge clock);
        check("pre_reset_rd_valid", 64'(rd_valid), 64'(1));
        #2 reset = 1'b1;
        #1;
        check("mid_rst_rd_valid", 64'(rd_valid), 64'(0));
        check("mid_rst_rd_pc", rd_pc, 64'(0));
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_count", 64'(count), 64'(0));
        check("mid_rst_triggered", 64'(triggered), 64'(0));
        @(negedge clock);
        reset     = 1'b0;
        cap_valid = 1'b1;
        cap_pc    = 64'd40;
        repeat (2) @(negedge clock);
        cap_valid = 1'b0;
        check("post_rst_count", 64'(count), 64'(0));
        check("post_rst_busy", 64'(busy), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
